coord_rotator: RTL and testbench

//  Consumes the registered Q7.10 sine word from the sine lookup and a matching cosine word, and rotates

---
 rtl/rot_pkg.sv | 21 ++
 rtl/rot_mac_lane.sv | 56 +++++
 rtl/coord_rotator.sv | 91 +++++++++
 tb/tb_coord_rotator.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared widths, rounding constant and coordinate types for the coordinate rotator.
// Coefficients are signed Q7.10; centred coordinates are signed COORD_W+1 bits.
package rot_pkg;
   localparam int Q_W        = 17;
   localparam int FRAC       = 10;
   localparam int COORD_W    = 9;
   localparam int IMG_W      = 256;
   localparam int IMG_H      = 256;
   localparam int CX         = 128;
   localparam int CY         = 128;
   localparam int ROUND_HALF = 1 << (FRAC - 1);

   localparam int C_W    = COORD_W + 1;   // centred coordinate
   localparam int PROD_W = Q_W + C_W;     // 27-bit product
   localparam int SUM_W  = PROD_W + 1;    // 28-bit sum/difference
   localparam int OUT_W  = COORD_W + 2;   // signed rotated coordinate

   typedef logic signed [Q_W-1:0]   coef_t;
   typedef logic signed [C_W-1:0]   cent_t;
   typedef logic signed [OUT_W-1:0] coord_out_t;
endpackage

// File: rtl/rot_mac_lane.sv
// One rotation lane: S1 two products, S2 sum or difference, S3 half-up rounding plus centre offset.
// All stage registers advance together on i_en; validity is tracked by the caller.
module rot_mac_lane
   import rot_pkg::*;
#(
   parameter bit SUBTRACT = 1'b0,
   parameter int OFFSET   = CX
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_en,
   input  logic signed [C_W-1:0]   i_a,
   input  logic signed [Q_W-1:0]   i_ca,
   input  logic signed [C_W-1:0]   i_b,
   input  logic signed [Q_W-1:0]   i_cb,
   output logic signed [OUT_W-1:0] o_res_next,
   output logic signed [OUT_W-1:0] o_res
);
   logic signed [PROD_W-1:0] w_a_ext, w_ca_ext, w_b_ext, w_cb_ext;
   logic signed [PROD_W-1:0] r_pa, r_pb;
   logic signed [SUM_W-1:0]  w_pa_ext, w_pb_ext, w_sum, w_biased;
   logic signed [SUM_W-1:0]  r_sum;
   logic signed [OUT_W-1:0]  w_res, r_res;
   logic                     w_unused_bits;

   assign w_a_ext  = i_a;
   assign w_ca_ext = i_ca;
   assign w_b_ext  = i_b;
   assign w_cb_ext = i_cb;

   assign w_pa_ext = r_pa;
   assign w_pb_ext = r_pb;
   assign w_sum    = SUBTRACT ? (w_pa_ext - w_pb_ext) : (w_pa_ext + w_pb_ext);

   // Taking bits [FRAC +: OUT_W] of the biased sum is the arithmetic shift followed by truncation.
   assign w_biased      = r_sum + SUM_W'(ROUND_HALF);
   assign w_res         = w_biased[FRAC +: OUT_W] + OUT_W'(OFFSET);
   assign w_unused_bits = ^{w_biased[SUM_W-1:FRAC+OUT_W], w_biased[FRAC-1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pa  <= '0;
         r_pb  <= '0;
         r_sum <= '0;
         r_res <= '0;
      end else if (i_en) begin
         r_pa  <= w_a_ext * w_ca_ext;
         r_pb  <= w_b_ext * w_cb_ext;
         r_sum <= w_sum;
         r_res <= w_res;
      end
   end

   assign o_res_next = w_res;
   assign o_res      = r_res;
endmodule

// File: rtl/coord_rotator.sv
// Rotates pixel coordinates about (CX,CY) with a loadable sin/cos pair; 3-stage valid/ready pipeline.
// A stalled output freezes every stage; angle loads block input acceptance for that cycle.
module coord_rotator
   import rot_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    angle_load,
   input  logic signed [Q_W-1:0]   sin_in,
   input  logic signed [Q_W-1:0]   cos_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [COORD_W-1:0]      x_in,
   input  logic [COORD_W-1:0]      y_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] x_out,
   output logic signed [OUT_W-1:0] y_out,
   output logic                    in_bounds
);
   coef_t      r_sin, r_cos;
   logic       r_v1, r_v2, r_v3;
   logic       r_in_bounds;
   logic       w_stall, w_adv, w_accept;
   cent_t      w_xc, w_yc;
   coord_out_t w_x_next, w_y_next;
   logic       w_ib_next;

   assign w_stall  = r_v3 & ~out_ready;
   assign w_adv    = ~w_stall;
   assign in_ready = ~w_stall & ~angle_load;
   assign w_accept = in_valid & in_ready;

   assign w_xc = $signed({1'b0, x_in}) - C_W'(CX);
   assign w_yc = $signed({1'b0, y_in}) - C_W'(CY);

   // Coefficients load even while stalled; data already captured keeps its products.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sin <= '0;
         r_cos <= '0;
      end else if (angle_load) begin
         r_sin <= sin_in;
         r_cos <= cos_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_v3        <= 1'b0;
         r_in_bounds <= 1'b0;
      end else if (w_adv) begin
         r_v1        <= w_accept;
         r_v2        <= r_v1;
         r_v3        <= r_v2;
         r_in_bounds <= r_v2 & w_ib_next;
      end
   end

   rot_mac_lane #(.SUBTRACT(1'b0), .OFFSET(CX)) u_x_lane (
      .clk        (clk),
      .reset      (reset),
      .i_en       (w_adv),
      .i_a        (w_xc),
      .i_ca       (r_cos),
      .i_b        (w_yc),
      .i_cb       (r_sin),
      .o_res_next (w_x_next),
      .o_res      (x_out)
   );

   rot_mac_lane #(.SUBTRACT(1'b1), .OFFSET(CY)) u_y_lane (
      .clk        (clk),
      .reset      (reset),
      .i_en       (w_adv),
      .i_a        (w_yc),
      .i_ca       (r_cos),
      .i_b        (w_xc),
      .i_cb       (r_sin),
      .o_res_next (w_y_next),
      .o_res      (y_out)
   );

   assign w_ib_next = ~w_x_next[OUT_W-1] && (w_x_next < OUT_W'(IMG_W)) &&
                      ~w_y_next[OUT_W-1] && (w_y_next < OUT_W'(IMG_H));

   assign out_valid = r_v3;
   assign in_bounds = r_in_bounds;
endmodule

// File: tb/tb_coord_rotator.sv
// Randomised and directed bench for coord_rotator against a real-arithmetic rotation model
// with a FIFO scoreboard; one compare process samples on the falling edge.
module tb_coord_rotator;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic angle_load = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic signed [16:0] sin_in = '0;
   logic signed [16:0] cos_in = '0;
   logic [8:0] x_in = '0;
   logic [8:0] y_in = '0;
   logic in_ready, out_valid, in_bounds;
   logic signed [10:0] x_out, y_out;

   coord_rotator dut (
      .clk        (clk),
      .reset      (reset),
      .angle_load (angle_load),
      .sin_in     (sin_in),
      .cos_in     (cos_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x_in       (x_in),
      .y_in       (y_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .x_out      (x_out),
      .y_out      (y_out),
      .in_bounds  (in_bounds)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit ib;
      int cyc;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int m_sin = 0;
   int m_cos = 0;
   int n_out = 0;
   int last_x = 0, last_y = 0, last_lat = 0;
   int last_ib = 0;
   bit prev_stall = 1'b0;
   int hold_x = 0, hold_y = 0, hold_ib = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Rotation about (128,128), rounded half-up, wrapped to an 11-bit signed result.
   function automatic exp_t model(input int x, input int y, input int s, input int c);
      exp_t e;
      real xc, yc;
      int rx, ry;
      xc = x - 128;
      yc = y - 128;
      rx = int'($floor((xc * c + yc * s) / 1024.0 + 0.5)) + 128;
      ry = int'($floor((yc * c - xc * s) / 1024.0 + 0.5)) + 128;
      rx = rx & 2047;
      ry = ry & 2047;
      if (rx >= 1024) rx -= 2048;
      if (ry >= 1024) ry -= 2048;
      e.x = rx;
      e.y = ry;
      e.ib = (rx >= 0) && (rx < 256) && (ry >= 0) && (ry < 256);
      e.cyc = 0;
      return e;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Single compare process: sees the values the next rising edge will act on.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         q.delete();
         m_sin = 0;
         m_cos = 0;
         prev_stall = 1'b0;
         chk("reset_out_valid", int'(out_valid), 0);
         chk("reset_x_out", int'(x_out), 0);
         chk("reset_y_out", int'(y_out), 0);
         chk("reset_in_bounds", int'(in_bounds), 0);
      end else begin
         chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready) && !angle_load));
         if (prev_stall) begin
            chk("stall_hold_valid", int'(out_valid), 1);
            chk("stall_hold_x", int'(x_out), hold_x);
            chk("stall_hold_y", int'(y_out), hold_y);
            chk("stall_hold_ib", int'(in_bounds), hold_ib);
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_output: got out_valid=1 x=%0d y=%0d expected no pending pixel",
                        x_out, y_out);
            end else if (out_ready) begin
               exp_t e;
               e = q.pop_front();
               chk("x_out", int'(x_out), e.x);
               chk("y_out", int'(y_out), e.y);
               chk("in_bounds", int'(in_bounds), int'(e.ib));
               last_x = x_out;
               last_y = y_out;
               last_ib = int'(in_bounds);
               last_lat = cyc - e.cyc;
               n_out++;
               $display("OUT  #%0d x=%0d y=%0d ib=%0d lat=%0d", n_out, x_out, y_out, in_bounds, last_lat);
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            e = model(int'(x_in), int'(y_in), m_sin, m_cos);
            e.cyc = cyc;
            q.push_back(e);
         end
         if (angle_load) begin
            m_sin = int'(sin_in);
            m_cos = int'(cos_in);
         end
         prev_stall = out_valid && !out_ready;
         hold_x = int'(x_out);
         hold_y = int'(y_out);
         hold_ib = int'(in_bounds);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coef(input int s, input int c);
      angle_load = 1'b1;
      sin_in = s[16:0];
      cos_in = c[16:0];
      step();
      angle_load = 1'b0;
   endtask

   task automatic wait_out(input int n0, input string name);
      for (int t = 0; t < 30 && n_out == n0; t++) step();
      checks++;
      if (n_out == n0) begin
         errors++;
         $display("FAIL %s_timeout: got no output expected one within 30 cycles", name);
      end
   endtask

   task automatic send_wait(input int x, input int y, input string name);
      int n0;
      bit acc;
      n0 = n_out;
      acc = 1'b0;
      in_valid = 1'b1;
      x_in = x[8:0];
      y_in = y[8:0];
      for (int t = 0; t < 50 && !acc; t++) begin
         #1;
         acc = in_ready;
         step();
      end
      in_valid = 1'b0;
      wait_out(n0, name);
   endtask

   task automatic pin(input string name, input int ex, input int ey, input int eib);
      chk({name, "_x"}, last_x, ex);
      chk({name, "_y"}, last_y, ey);
      chk({name, "_ib"}, last_ib, eib);
   endtask

   initial begin
      int n0;
      int idx;
      int px[8];
      int py[8];
      bit acc;

      repeat (3) step();
      reset = 1'b1;
      step();

      // Coefficients are zero after reset: every pixel collapses to the centre.
      send_wait(50, 60, "zero_coef");
      pin("zero_coef", 128, 128, 1);

      set_coef(0, 1024);
      send_wait(10, 200, "deg0");
      pin("deg0", 10, 200, 1);
      chk("deg0_latency", last_lat, 3);

      set_coef(1024, 0);
      send_wait(138, 128, "deg90a");
      pin("deg90a", 128, 118, 1);
      send_wait(128, 138, "deg90b");
      pin("deg90b", 138, 128, 1);

      set_coef(736, 736);
      send_wait(228, 128, "deg45");
      pin("deg45", 200, 56, 1);
      send_wait(0, 0, "deg45_corner");
      pin("deg45_corner", -56, 128, 0);

      set_coef(-266, 989);
      send_wait(255, 255, "degm15");
      pin("degm15", 218, 284, 0);

      // Backpressure: eight back-to-back pixels, output blocked for cycles 4..7.
      set_coef(736, 736);
      for (int i = 0; i < 8; i++) begin
         px[i] = $urandom_range(0, 255);
         py[i] = $urandom_range(0, 255);
      end
      n0 = n_out;
      idx = 0;
      for (int k = 0; k < 40; k++) begin
         out_ready = !(k >= 4 && k <= 7);
         if (idx < 8) begin
            in_valid = 1'b1;
            x_in = px[idx][8:0];
            y_in = py[idx][8:0];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && in_ready) idx++;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_count", n_out - n0, 8);

      // Reset with pixels in flight.
      set_coef(0, 1024);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         x_in = 9'(20 + i);
         y_in = 9'(30 + i);
         step();
      end
      in_valid = 1'b0;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      n0 = n_out;
      repeat (6) step();
      chk("post_reset_outputs", n_out - n0, 0);
      send_wait(77, 99, "post_reset_zero");
      pin("post_reset_zero", 128, 128, 1);

      // Angle load together with a pixel: pixel must wait one cycle and use the new angle.
      n0 = n_out;
      angle_load = 1'b1;
      sin_in = 17'sd1024;
      cos_in = 17'sd0;
      in_valid = 1'b1;
      x_in = 9'd138;
      y_in = 9'd128;
      #1;
      chk("load_blocks_ready", int'(in_ready), 0);
      step();
      angle_load = 1'b0;
      #1;
      chk("retry_ready", int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      wait_out(n0, "load_retry");
      pin("load_retry", 128, 118, 1);

      // Random traffic with random stalls and angle changes.
      acc = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         angle_load = ($urandom_range(0, 15) == 0);
         if (angle_load) begin
            int s, c;
            if ($urandom_range(0, 3) == 0) begin
               s = int'($urandom_range(0, 131071)) - 65536;
               c = int'($urandom_range(0, 131071)) - 65536;
            end else begin
               s = int'($urandom_range(0, 2048)) - 1024;
               c = int'($urandom_range(0, 2048)) - 1024;
            end
            sin_in = s[16:0];
            cos_in = c[16:0];
         end
         if (acc || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            x_in = 9'($urandom_range(0, 511));
            y_in = 9'($urandom_range(0, 511));
         end
         #1;
         acc = in_valid && in_ready;
         step();
      end
      angle_load = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) step();
      chk("drain_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
